jtframe_sdram_arb: RTL and testbench



---
 rtl/jtframe_sdram_arb.sv | 116 +++++++++++
 tb/tb_jtframe_sdram_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: four-slot read cache arbitrating misses onto a single SDRAM port.
module jtframe_sdram_arb #(
  parameter int AW    = 22,
  parameter bit PRIO0 = 1'b0
) (
  input  logic              clk_rom,
  input  logic              rst_n,
  input  logic [3:0]        slot_req,
  input  logic [4*AW-1:0]   slot_addr,
  output logic [3:0]        slot_ok,
  output logic [127:0]      slot_dout,
  input  logic              downloading,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic [31:0]       data_read,
  input  logic              data_rdy,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   addr_a [4];
  logic [AW-1:0]   cache_addr_q [4], cache_addr_d [4];
  logic [31:0]     cache_data_q [4], cache_data_d [4];
  logic [3:0]      hit, pending, valid_q, valid_d;
  logic [1:0]      g_q, g_d, last_q, last_d, sel, idx;
  logic [AW-1:0]   addr_q, addr_d;
  logic            fill, found;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_slot
      assign addr_a[i]              = slot_addr[i*AW +: AW];
      assign hit[i]                 = valid_q[i] & (cache_addr_q[i] == addr_a[i]);
      assign slot_dout[i*32 +: 32]  = cache_data_q[i];
    end
  endgenerate

  assign pending    = slot_req & ~hit;
  assign slot_ok    = slot_req & hit;
  assign sdram_req  = state_q == WAIT_ACK;
  assign busy       = state_q != IDLE;
  assign sdram_addr = addr_q;

  // Round-robin search from last+1; slot 0 pre-empts when PRIO0 is set.
  always_comb begin
    sel   = last_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    if (PRIO0 && pending[0]) sel = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    addr_d  = addr_q;
    fill    = 1'b0;
    case (state_q)
      IDLE: if (|pending && !downloading) begin
        state_d = WAIT_ACK;
        g_d     = sel;
        last_d  = sel;
        addr_d  = addr_a[sel];
      end
      WAIT_ACK: if (sdram_ack) begin
        state_d = data_rdy ? IDLE : WAIT_RDY;
        fill    = data_rdy;
      end
      WAIT_RDY: if (data_rdy) begin
        state_d = IDLE;
        fill    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fill during a download still lands its data but never marks it valid.
  always_comb begin
    valid_d      = downloading ? 4'd0 : valid_q;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;
    if (fill) begin
      cache_data_d[g_q] = data_read;
      cache_addr_d[g_q] = addr_q;
      valid_d[g_q]      = ~downloading;
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      g_q          <= 2'd0;
      last_q       <= 2'd3;
      addr_q       <= '0;
      valid_q      <= 4'd0;
      cache_addr_q <= '{default: '0};
      cache_data_q <= '{default: '0};
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
    end
  end
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// tb_jtframe_sdram_arb: drives a round-robin and a slot-0-priority arbiter against a transaction-level cache model.
module tb_jtframe_sdram_arb;
  localparam int AW = 22;
  logic              clk_rom = 1'b0;
  logic              rst_n;
  logic [3:0]        slot_req;
  logic [4*AW-1:0]   slot_addr, addr_v;
  logic              downloading;
  logic [31:0]       data_read;
  logic [1:0]        ack_v, rdy_v;
  logic [3:0]        ok [2];
  logic [127:0]      dout [2];
  logic              sreq [2];
  logic [AW-1:0]     saddr [2];
  logic              bsy [2];
  int                tests = 0, fails = 0;

  logic [AW-1:0]     c_addr [2][4];
  logic [31:0]       c_data [2][4];
  bit                c_valid [2][4];
  bit                m_inf [2], m_ack [2];
  int                m_g [2], m_last [2];
  logic [AW-1:0]     m_addr [2];

  always #5 clk_rom = ~clk_rom;

  jtframe_sdram_arb #(.AW(AW), .PRIO0(1'b0)) dut0 (
    .clk_rom(clk_rom), .rst_n(rst_n), .slot_req(slot_req), .slot_addr(slot_addr),
    .slot_ok(ok[0]), .slot_dout(dout[0]), .downloading(downloading),
    .sdram_req(sreq[0]), .sdram_addr(saddr[0]), .sdram_ack(ack_v[0]),
    .data_read(data_read), .data_rdy(rdy_v[0]), .busy(bsy[0]));

  jtframe_sdram_arb #(.AW(AW), .PRIO0(1'b1)) dut1 (
    .clk_rom(clk_rom), .rst_n(rst_n), .slot_req(slot_req), .slot_addr(slot_addr),
    .slot_ok(ok[1]), .slot_dout(dout[1]), .downloading(downloading),
    .sdram_req(sreq[1]), .sdram_addr(saddr[1]), .sdram_ack(ack_v[1]),
    .data_read(data_read), .data_rdy(rdy_v[1]), .busy(bsy[1]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*AW-1:0] pk(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic int pick(input int p, input logic [3:0] pend, input int last);
    if (p == 1 && pend[0]) return 0;
    for (int k = 1; k <= 4; k++)
      if (pend[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic mreset();
    for (int p = 0; p < 2; p++) begin
      m_inf[p] = 0; m_ack[p] = 0; m_g[p] = 0; m_last[p] = 3; m_addr[p] = '0;
      for (int i = 0; i < 4; i++) begin
        c_addr[p][i] = '0; c_data[p][i] = '0; c_valid[p][i] = 0;
      end
    end
  endtask

  task automatic mcheck(input int p);
    logic [3:0]   eo;
    logic [127:0] ed;
    for (int i = 0; i < 4; i++) begin
      eo[i] = slot_req[i] & c_valid[p][i] & (c_addr[p][i] == slot_addr[i*AW +: AW]);
      ed[i*32 +: 32] = c_data[p][i];
    end
    chk($sformatf("busy%0d", p), 128'(bsy[p]), 128'(m_inf[p]));
    chk($sformatf("req%0d", p), 128'(sreq[p]), 128'(m_inf[p] && !m_ack[p]));
    chk($sformatf("addr%0d", p), 128'(saddr[p]), 128'(m_addr[p]));
    chk($sformatf("ok%0d", p), 128'(ok[p]), 128'(eo));
    chk($sformatf("dout%0d", p), dout[p], ed);
  endtask

  task automatic mupdate(input int p);
    logic [3:0] pend;
    bit idle, fill;
    int g;
    for (int i = 0; i < 4; i++)
      pend[i] = slot_req[i] & !(c_valid[p][i] && c_addr[p][i] == slot_addr[i*AW +: AW]);
    idle = !m_inf[p];
    fill = m_inf[p] && rdy_v[p] && (m_ack[p] || ack_v[p]);
    if (downloading) for (int i = 0; i < 4; i++) c_valid[p][i] = 0;
    if (fill) begin
      c_data[p][m_g[p]]  = data_read;
      c_addr[p][m_g[p]]  = m_addr[p];
      c_valid[p][m_g[p]] = !downloading;
      m_inf[p] = 0;
    end else if (m_inf[p] && ack_v[p]) m_ack[p] = 1;
    if (idle && !downloading && pend != 4'd0) begin
      g = pick(p, pend, m_last[p]);
      m_g[p] = g; m_last[p] = g; m_inf[p] = 1; m_ack[p] = 0;
      m_addr[p] = slot_addr[g*AW +: AW];
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [1:0] ak, input logic [1:0] rd,
                      input logic [31:0] d, input logic dl);
    slot_req = r; slot_addr = addr_v; ack_v = ak; rdy_v = rd; data_read = d; downloading = dl;
    #1;
    for (int p = 0; p < 2; p++) mcheck(p);
    for (int p = 0; p < 2; p++) mupdate(p);
    @(posedge clk_rom);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rst_busy%0d", p), 128'(bsy[p]), 128'(0));
      chk($sformatf("rst_req%0d", p), 128'(sreq[p]), 128'(0));
      chk($sformatf("rst_addr%0d", p), 128'(saddr[p]), 128'(0));
      chk($sformatf("rst_ok%0d", p), 128'(ok[p]), 128'(0));
      chk($sformatf("rst_dout%0d", p), dout[p], 128'(0));
    end
    mreset();
    repeat (2) @(posedge clk_rom);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] ra [4];
    logic [1:0] ak, rd;
    slot_req = '0; slot_addr = '0; addr_v = '0; downloading = 0;
    data_read = '0; ack_v = '0; rdy_v = '0;
    do_reset();

    // single miss on slot 2, ack at cycle 3, data at cycle 6
    addr_v = pk(0, 0, 22'h1234, 0);
    for (int c = 0; c <= 6; c++) begin
      step(4'b0100, c == 3 ? 2'b11 : 2'b00, c == 6 ? 2'b11 : 2'b00, 32'hDEADBEEF, 0);
      if (c < 6) chk($sformatf("s1_req_c%0d", c + 1), 128'(sreq[0]), 128'(c < 3));
    end
    chk("s1_ok", 128'(ok[0][2]), 128'(1));
    chk("s1_dout", 128'(dout[0][95:64]), 128'(32'hDEADBEEF));
    step(4'b0000, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 0);
    chk("s2_ok", 128'(ok[0][2]), 128'(1));
    chk("s2_req", 128'(sreq[0]), 128'(0));

    // all four slots miss after reset: two full rounds from slot 0
    do_reset();
    for (int rnd = 0; rnd < 2; rnd++) begin
      addr_v = rnd == 0 ? pk(22'h100, 22'h101, 22'h102, 22'h103)
                        : pk(22'h200, 22'h201, 22'h202, 22'h203);
      for (int s = 0; s < 4; s++) begin
        step(4'b1111, 0, 0, 0, 0);
        chk($sformatf("s3_grant_r%0d_s%0d", rnd, s), 128'(saddr[0]), 128'(addr_v[s*AW +: AW]));
        step(4'b1111, 2'b11, 0, 0, 0);
        step(4'b1111, 0, 2'b11, 32'hA000_0000 + 32'(rnd * 4 + s), 0);
      end
    end

    // slot 0 priority against slot 3
    for (int r = 0; r < 4; r++) begin
      addr_v = pk(22'h500 + 22'(r < 3 ? r : 2), 0, 0, 22'h700);
      step(4'b1001, 0, 0, 0, 0);
      chk($sformatf("s4_prio_r%0d", r), 128'(saddr[1]), 128'(r < 3 ? 22'h500 + 22'(r) : 22'h700));
      step(4'b1001, 2'b11, 0, 0, 0);
      step(4'b1001, 0, 2'b11, 32'h5555_0000 + 32'(r), 0);
    end

    // slot 1 address changes while waiting for data
    addr_v = pk(0, 22'h10, 0, 0);
    step(4'b0010, 0, 0, 0, 0);
    step(4'b0010, 2'b11, 0, 0, 0);
    addr_v = pk(0, 22'h20, 0, 0);
    step(4'b0010, 0, 0, 0, 0);
    step(4'b0010, 0, 2'b11, 32'h1111_1111, 0);
    chk("s5_ok_stale", 128'(ok[0][1]), 128'(0));
    step(4'b0010, 0, 0, 0, 0);
    chk("s5_regrant_addr", 128'(saddr[0]), 128'(22'h20));
    chk("s5_regrant_req", 128'(sreq[0]), 128'(1));
    step(4'b0010, 2'b11, 0, 0, 0);
    step(4'b0010, 0, 2'b11, 32'h2222_2222, 0);
    chk("s5_ok_new", 128'(ok[0][1]), 128'(1));

    // download during WAIT_RDY
    addr_v = pk(0, 22'h20, 22'h3333, 0);
    step(4'b0110, 0, 0, 0, 0);
    step(4'b0110, 2'b11, 0, 0, 0);
    step(4'b0110, 0, 2'b11, 32'h3333_3333, 1);
    chk("s6_ok_none", 128'(ok[0]), 128'(0));
    chk("s6_busy", 128'(bsy[0]), 128'(0));
    step(4'b0110, 0, 0, 0, 1);
    chk("s6_nogrant", 128'(sreq[0]), 128'(0));
    step(4'b0110, 0, 0, 0, 0);
    chk("s6_grant", 128'(sreq[0]), 128'(1));

    // reset while in WAIT_ACK
    do_reset();
    addr_v = pk(22'h40, 22'h41, 22'h42, 22'h43);
    step(4'b1111, 0, 0, 0, 0);
    chk("s7_first0", 128'(saddr[0]), 128'(22'h40));
    chk("s7_first1", 128'(saddr[1]), 128'(22'h40));

    // random traffic
    for (int i = 0; i < 4; i++) ra[i] = AW'($urandom_range(0, 7));
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) ra[i] = AW'($urandom_range(0, 7));
      addr_v = pk(ra[0], ra[1], ra[2], ra[3]);
      for (int p = 0; p < 2; p++) begin
        ak[p] = m_inf[p] && !m_ack[p] && ($urandom_range(0, 2) == 0);
        rd[p] = m_inf[p] && (m_ack[p] || ak[p]) && ($urandom_range(0, 2) == 0);
      end
      step(4'($urandom), ak, rd, $urandom, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
